// File: rtl/rtc_edit_ctrl_pkg.sv
// Purpose: shared field indices, BCD range constants, FSM states and
//          field pack/unpack helpers for the RTC edit controller.
// Latency: n/a (declarations only). Backpressure: n/a.
package rtc_edit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Field indices; field i lives at bits [8*i +: 8] of the packed BCD buses.
  localparam logic [2:0] F_SEG  = 3'd0;
  localparam logic [2:0] F_MIN  = 3'd1;
  localparam logic [2:0] F_HORA = 3'd2;
  localparam logic [2:0] F_DIA  = 3'd3;
  localparam logic [2:0] F_MES  = 3'd4;
  localparam logic [2:0] F_ANO  = 3'd5;

  localparam logic [2:0] CUR_LAST_CLK = 3'd5;
  localparam logic [2:0] CUR_LAST_TMR = 3'd2;

  localparam logic [7:0] BCD_00   = 8'h00;
  localparam logic [7:0] BCD_01   = 8'h01;
  localparam logic [7:0] SEG_MAX  = 8'h59;
  localparam logic [7:0] HORA_MAX = 8'h23;
  localparam logic [7:0] MES_MAX  = 8'h12;
  localparam logic [7:0] ANO_MAX  = 8'h99;

  function automatic logic [7:0] field_get(input logic [47:0] v, input logic [2:0] idx);
    logic [7:0] f;
    case (idx)
      F_SEG:   f = v[7:0];
      F_MIN:   f = v[15:8];
      F_HORA:  f = v[23:16];
      F_DIA:   f = v[31:24];
      F_MES:   f = v[39:32];
      default: f = v[47:40];
    endcase
    return f;
  endfunction

  function automatic logic [47:0] field_set(input logic [47:0] v, input logic [2:0] idx,
                                            input logic [7:0] f);
    logic [47:0] r;
    r = v;
    case (idx)
      F_SEG:   r[7:0]   = f;
      F_MIN:   r[15:8]  = f;
      F_HORA:  r[23:16] = f;
      F_DIA:   r[31:24] = f;
      F_MES:   r[39:32] = f;
      default: r[47:40] = f;
    endcase
    return r;
  endfunction

  // Last day of the month in BCD. Leap years are simply years divisible by 4
  // (two-digit year, 2000-2099 window).
  function automatic logic [7:0] dmax_of(input logic [7:0] mes, input logic [7:0] ano);
    logic [7:0] ano_bin;
    logic [7:0] d;
    ano_bin = ({4'd0, ano[7:4]} * 8'd10) + {4'd0, ano[3:0]};
    case (mes)
      8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
      8'h02:                      d = (ano_bin[1:0] == 2'b00) ? 8'h29 : 8'h28;
      default:                    d = 8'h31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Purpose: steps one 2-digit BCD field up or down with wrap inside [min,max].
// Latency: combinational. Backpressure: none.
// Ports: val/min/max BCD bytes, up/dn step requests (up wins), next = result.
//        An out-of-range or non-BCD val is forced to min on any step.
module bcd_field_step (
  input  logic [7:0] val,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       up,
  input  logic       dn,
  output logic [7:0] next
);

  logic       valid;
  logic [7:0] inc;
  logic [7:0] dec;

  always_comb begin
    // Byte compares equal numeric compares once both nibbles are <= 9.
    valid = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val >= min) && (val <= max);
    inc   = (val[3:0] == 4'd9) ? {val[7:4] + 4'd1, 4'd0} : {val[7:4], val[3:0] + 4'd1};
    dec   = (val[3:0] == 4'd0) ? {val[7:4] - 4'd1, 4'd9} : {val[7:4], val[3:0] - 4'd1};
    next  = val;
    if (up || dn) begin
      if (!valid)
        next = min;
      else if (up)
        next = (val == max) ? min : inc;
      else
        next = (val == min) ? max : dec;
    end
  end

endmodule

// File: rtl/rtc_edit_ctrl.sv
// Purpose: button FSM for editing RTC clock/date or timer fields and committing
//          them to the RTC write FSM; also drives the VGA mux selects.
// Latency: 1 cycle from button pulse to registered outputs.
// Backpressure: none on buttons; commit holds in WAIT until wr_done or timeout.
// Ports: clk/reset (sync, active-high); btn_* one-cycle pulses; rtc_*_bcd live
//        values; wr_done write ack; En_Escr/En_clock mux selects; usu_*_bcd user
//        values; cursor field index; wr_req/wr_err one-cycle pulses.
module rtc_edit_ctrl
  import rtc_edit_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200_000,
  parameter int TW          = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_edit,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [47:0] rtc_clk_bcd,
  input  logic [23:0] rtc_tmr_bcd,
  input  logic        wr_done,
  output logic        En_Escr,
  output logic        En_clock,
  output logic [47:0] usu_clk_bcd,
  output logic [23:0] usu_tmr_bcd,
  output logic [2:0]  cursor,
  output logic        wr_req,
  output logic        wr_err
);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;

  logic [7:0]  fval, fmin, fmax, fnext, dmax_cur, dmax_new;
  logic [47:0] clk_step, clk_edit;
  logic [23:0] tmr_edit;
  logic [2:0]  cur_last;

  // Selected field and its legal range; one stepper serves every field.
  always_comb begin
    dmax_cur = dmax_of(usu_clk_bcd[39:32], usu_clk_bcd[47:40]);
    fval     = En_clock ? field_get(usu_clk_bcd, cursor) : field_get({24'h0, usu_tmr_bcd}, cursor);
    fmin     = BCD_00;
    fmax     = ANO_MAX;
    case (cursor)
      F_SEG, F_MIN: fmax = SEG_MAX;
      F_HORA:       fmax = HORA_MAX;
      F_DIA: begin
        fmin = BCD_01;
        fmax = dmax_cur;
      end
      F_MES: begin
        fmin = BCD_01;
        fmax = MES_MAX;
      end
      default:      fmax = ANO_MAX;
    endcase
  end

  bcd_field_step u_step (
    .val  (fval),
    .min  (fmin),
    .max  (fmax),
    .up   (btn_up),
    .dn   (btn_down & ~btn_up),
    .next (fnext)
  );

  // Write-back images. A month/year change re-evaluates the month length
  // with the new values and pulls the day down if it no longer fits.
  always_comb begin
    clk_step = field_set(usu_clk_bcd, cursor, fnext);
    dmax_new = dmax_of(clk_step[39:32], clk_step[47:40]);
    clk_edit = clk_step;
    if (((cursor == F_MES) || (cursor == F_ANO)) && (clk_step[31:24] > dmax_new))
      clk_edit[31:24] = dmax_new;

    tmr_edit = usu_tmr_bcd;
    case (cursor)
      F_SEG:   tmr_edit[7:0]   = fnext;
      F_MIN:   tmr_edit[15:8]  = fnext;
      default: tmr_edit[23:16] = fnext;
    endcase

    cur_last = En_clock ? CUR_LAST_CLK : CUR_LAST_TMR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      En_Escr     <= 1'b0;
      En_clock    <= 1'b1;
      cursor      <= 3'd0;
      wr_req      <= 1'b0;
      wr_err      <= 1'b0;
      usu_clk_bcd <= '0;
      usu_tmr_bcd <= '0;
      tmo_cnt     <= '0;
    end else begin
      wr_req <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_edit) begin
            usu_clk_bcd <= rtc_clk_bcd;
            usu_tmr_bcd <= rtc_tmr_bcd;
            cursor      <= 3'd0;
            En_Escr     <= 1'b1;
            state       <= ST_EDIT;
          end else if (btn_mode) begin
            En_clock <= ~En_clock;
          end
        end
        ST_EDIT: begin
          if (btn_edit) begin
            wr_req  <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_WAIT;
          end else if (btn_mode) begin
            En_Escr <= 1'b0;
            state   <= ST_IDLE;
          end else if (btn_up || btn_down) begin
            if (En_clock)
              usu_clk_bcd <= clk_edit;
            else
              usu_tmr_bcd <= tmr_edit;
          end else if (btn_left) begin
            cursor <= (cursor == cur_last) ? 3'd0 : cursor + 3'd1;
          end else if (btn_right) begin
            cursor <= (cursor == 3'd0) ? cur_last : cursor - 3'd1;
          end
        end
        ST_WAIT: begin
          // wr_done on the terminal-count cycle wins over the timeout.
          if (wr_done) begin
            En_Escr <= 1'b0;
            state   <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            wr_err  <= 1'b1;
            En_Escr <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          En_Escr <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
module tb_rtc_edit_ctrl;

  localparam int TMO = 16;
  localparam logic [6:0] B_EDIT = 7'h01, B_MODE = 7'h02, B_UP = 7'h04, B_DN = 7'h08,
                         B_LEFT = 7'h10, B_RIGHT = 7'h20, B_DONE = 7'h40;
  localparam int M_IDLE = 0, M_EDIT = 1, M_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_edit, btn_mode, btn_up, btn_down, btn_left, btn_right, wr_done;
  logic [47:0] rtc_clk_bcd;
  logic [23:0] rtc_tmr_bcd;
  logic        En_Escr, En_clock, wr_req, wr_err;
  logic [47:0] usu_clk_bcd;
  logic [23:0] usu_tmr_bcd;
  logic [2:0]  cursor;

  int checks = 0;
  int errors = 0;

  // Reference model: plain-integer view of the editor.
  int         m_mode, m_cur, m_wait;
  bit         m_show, m_tgt, m_req, m_err;
  logic [7:0] m_c[6];
  logic [7:0] m_t[3];

  always #5 clk = ~clk;

  rtc_edit_ctrl #(.TIMEOUT_CYC(TMO), .TW(18)) dut (
    .clk(clk), .reset(reset),
    .btn_edit(btn_edit), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .rtc_clk_bcd(rtc_clk_bcd), .rtc_tmr_bcd(rtc_tmr_bcd), .wr_done(wr_done),
    .En_Escr(En_Escr), .En_clock(En_clock), .usu_clk_bcd(usu_clk_bcd),
    .usu_tmr_bcd(usu_tmr_bcd), .cursor(cursor), .wr_req(wr_req), .wr_err(wr_err)
  );

  function automatic int dmax_int(input logic [7:0] mes, input logic [7:0] ano);
    int a;
    a = int'(ano[7:4]) * 10 + int'(ano[3:0]);
    case (mes)
      8'h04, 8'h06, 8'h09, 8'h11: return 30;
      8'h02:                      return (a % 4 == 0) ? 29 : 28;
      default:                    return 31;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic logic [7:0] rand_field(input int lo, input int hi);
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    return to_bcd(int'($urandom_range(hi, lo)));
  endfunction

  task automatic model_adjust(input bit up);
    logic [7:0] b;
    int lo, hi, n, d;
    bit ok;
    b  = m_tgt ? m_c[m_cur] : m_t[m_cur];
    lo = 0;
    hi = 99;
    case (m_cur)
      0, 1: hi = 59;
      2:    hi = 23;
      3: begin lo = 1; hi = dmax_int(m_c[4], m_c[5]); end
      4: begin lo = 1; hi = 12; end
      default: hi = 99;
    endcase
    n  = int'(b[7:4]) * 10 + int'(b[3:0]);
    ok = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (n >= lo) && (n <= hi);
    if (!ok)     n = lo;
    else if (up) n = (n == hi) ? lo : n + 1;
    else         n = (n == lo) ? hi : n - 1;
    if (m_tgt) begin
      m_c[m_cur] = to_bcd(n);
      if (m_cur >= 4) begin
        d = dmax_int(m_c[4], m_c[5]);
        if (m_c[3] > to_bcd(d)) m_c[3] = to_bcd(d);
      end
    end else begin
      m_t[m_cur] = to_bcd(n);
    end
  endtask

  task automatic model_step();
    int nf;
    m_req = 1'b0;
    m_err = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_show = 1'b0; m_tgt = 1'b1; m_cur = 0; m_wait = 0;
      for (int i = 0; i < 6; i++) m_c[i] = 8'h00;
      for (int i = 0; i < 3; i++) m_t[i] = 8'h00;
      return;
    end
    nf = m_tgt ? 6 : 3;
    case (m_mode)
      M_IDLE: begin
        if (btn_edit) begin
          for (int i = 0; i < 6; i++) m_c[i] = rtc_clk_bcd[8*i +: 8];
          for (int i = 0; i < 3; i++) m_t[i] = rtc_tmr_bcd[8*i +: 8];
          m_cur = 0; m_show = 1'b1; m_mode = M_EDIT;
        end else if (btn_mode) begin
          m_tgt = !m_tgt;
        end
      end
      M_EDIT: begin
        if (btn_edit) begin
          m_req = 1'b1; m_wait = 0; m_mode = M_WAIT;
        end else if (btn_mode) begin
          m_show = 1'b0; m_mode = M_IDLE;
        end else if (btn_up || btn_down) begin
          model_adjust(btn_up);
        end else if (btn_left) begin
          m_cur = (m_cur + 1) % nf;
        end else if (btn_right) begin
          m_cur = (m_cur + nf - 1) % nf;
        end
      end
      default: begin
        m_wait++;
        if (wr_done) begin
          m_show = 1'b0; m_mode = M_IDLE;
        end else if (m_wait == TMO) begin
          m_err = 1'b1; m_show = 1'b0; m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("m_En_Escr",  48'(En_Escr),  48'(m_show));
    check("m_En_clock", 48'(En_clock), 48'(m_tgt));
    check("m_cursor",   48'(cursor),   48'(m_cur));
    check("m_wr_req",   48'(wr_req),   48'(m_req));
    check("m_wr_err",   48'(wr_err),   48'(m_err));
    check("m_usu_clk",  usu_clk_bcd,   {m_c[5], m_c[4], m_c[3], m_c[2], m_c[1], m_c[0]});
    check("m_usu_tmr",  48'(usu_tmr_bcd), 48'({m_t[2], m_t[1], m_t[0]}));
  endtask

  // One clock: apply pulses, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic [6:0] b);
    btn_edit = b[0]; btn_mode = b[1]; btn_up = b[2]; btn_down = b[3];
    btn_left = b[4]; btn_right = b[5]; wr_done = b[6];
    model_step();
    @(posedge clk);
    #1;
    btn_edit = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    btn_left = 0; btn_right = 0; wr_done = 0;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_En_Escr"},  48'(En_Escr),  48'd0);
    check({tag, "_En_clock"}, 48'(En_clock), 48'd1);
    check({tag, "_cursor"},   48'(cursor),   48'd0);
    check({tag, "_wr_req"},   48'(wr_req),   48'd0);
    check({tag, "_wr_err"},   48'(wr_err),   48'd0);
    check({tag, "_usu_clk"},  usu_clk_bcd,   48'd0);
    check({tag, "_usu_tmr"},  48'(usu_tmr_bcd), 48'd0);
  endtask

  initial begin
    int req_cnt;
    logic [6:0] b;
    reset = 1'b1;
    btn_edit = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    btn_left = 0; btn_right = 0; wr_done = 0;
    rtc_clk_bcd = '0;
    rtc_tmr_bcd = '0;
    cycle(7'h0);
    cycle(7'h0);
    check_reset_vals("rst");
    reset = 1'b0;

    // Snapshot and BCD wrap on seconds / hours.
    rtc_clk_bcd = 48'h99_12_31_23_59_59;
    cycle(B_EDIT);
    check("load_clk", usu_clk_bcd, 48'h99_12_31_23_59_59);
    check("load_escr", 48'(En_Escr), 48'd1);
    check("load_eclk", 48'(En_clock), 48'd1);
    check("load_cur", 48'(cursor), 48'd0);
    cycle(B_UP);
    check("seg_up_wrap", 48'(usu_clk_bcd[7:0]), 48'h00);
    cycle(B_DN);
    check("seg_dn_wrap", 48'(usu_clk_bcd[7:0]), 48'h59);
    cycle(B_LEFT);
    cycle(B_LEFT);
    cycle(B_UP);
    check("hora_up_wrap", 48'(usu_clk_bcd[23:16]), 48'h00);
    cycle(B_MODE);
    check("cancel_escr", 48'(En_Escr), 48'd0);
    check("cancel_hold", usu_clk_bcd, 48'h99_12_31_00_59_59);

    // Month change clamps the day: non-leap then leap year.
    rtc_clk_bcd = 48'h23_01_31_12_00_00;
    cycle(B_EDIT);
    repeat (4) cycle(B_LEFT);
    check("cur_mes", 48'(cursor), 48'd4);
    cycle(B_UP);
    check("mes_02", 48'(usu_clk_bcd[39:32]), 48'h02);
    check("clamp_28", 48'(usu_clk_bcd[31:24]), 48'h28);
    cycle(B_MODE);
    rtc_clk_bcd = 48'h24_01_31_12_00_00;
    cycle(B_EDIT);
    repeat (4) cycle(B_LEFT);
    cycle(B_UP);
    check("clamp_29", 48'(usu_clk_bcd[31:24]), 48'h29);
    cycle(B_RIGHT);
    check("cur_dia", 48'(cursor), 48'd3);
    cycle(B_UP);
    check("dia_up_wrap", 48'(usu_clk_bcd[31:24]), 48'h01);
    cycle(B_DN);
    check("dia_dn_dmax", 48'(usu_clk_bcd[31:24]), 48'h29);
    cycle(B_MODE);

    // Timer target, cursor wrap, commit acknowledged after 10 cycles.
    cycle(B_MODE);
    check("tgt_timer", 48'(En_clock), 48'd0);
    rtc_tmr_bcd = 24'h12_34_56;
    cycle(B_EDIT);
    check("load_tmr", 48'(usu_tmr_bcd), 48'h12_34_56);
    repeat (3) cycle(B_LEFT);
    check("tmr_cur_wrap", 48'(cursor), 48'd0);
    cycle(B_EDIT);
    check("commit_req", 48'(wr_req), 48'd1);
    check("commit_tgt", 48'(En_clock), 48'd0);
    repeat (9) cycle(7'h0);
    check("wait_escr", 48'(En_Escr), 48'd1);
    cycle(B_DONE);
    check("done_escr", 48'(En_Escr), 48'd0);
    check("done_err", 48'(wr_err), 48'd0);

    // Timeout: wr_err exactly TMO cycles after the commit, single wr_req.
    cycle(B_MODE);
    cycle(B_EDIT);
    cycle(B_EDIT);
    req_cnt = int'(wr_req);
    for (int k = 1; k <= TMO; k++) begin
      cycle(7'h0);
      req_cnt += int'(wr_req);
      if (k < TMO) check("tmo_early", 48'(wr_err), 48'd0);
    end
    check("tmo_err", 48'(wr_err), 48'd1);
    check("tmo_escr", 48'(En_Escr), 48'd0);
    check("tmo_req_once", 48'(req_cnt), 48'd1);
    cycle(7'h0);
    check("tmo_err_pulse", 48'(wr_err), 48'd0);

    // wr_done on the terminal-count cycle is a success.
    cycle(B_EDIT);
    cycle(B_EDIT);
    repeat (TMO - 1) cycle(7'h0);
    cycle(B_DONE);
    check("term_done_err", 48'(wr_err), 48'd0);
    check("term_done_escr", 48'(En_Escr), 48'd0);

    // Edit beats up in the same cycle; buttons ignored in WAIT; reset from WAIT.
    cycle(B_EDIT);
    cycle(B_EDIT | B_UP);
    check("prio_req", 48'(wr_req), 48'd1);
    check("prio_seg", 48'(usu_clk_bcd[7:0]), 48'h00);
    cycle(B_UP);
    check("wait_frozen", 48'(usu_clk_bcd[7:0]), 48'h00);
    reset = 1'b1;
    cycle(7'h0);
    check_reset_vals("rst_wait");
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rtc_clk_bcd = {rand_field(0, 99), rand_field(1, 12), rand_field(1, 31),
                       rand_field(0, 23), rand_field(0, 59), rand_field(0, 59)};
        rtc_tmr_bcd = {rand_field(0, 23), rand_field(0, 59), rand_field(0, 59)};
      end
      b = '0;
      case ($urandom_range(0, 9))
        0, 1, 2: b = '0;
        3:       b = 7'($urandom) & 7'h3f;
        4:       b = B_EDIT;
        5:       b = B_MODE;
        6:       b = B_UP;
        7:       b = B_DN;
        8:       b = B_LEFT;
        default: b = B_RIGHT;
      endcase
      if ($urandom_range(0, 9) == 0) b = b | B_DONE;
      reset = ($urandom_range(0, 299) == 0);
      cycle(b);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
